// File: rtl/tdc_pulse_generator_pkg.sv
// Shared TDC constants: fine-chain length (matches the TDC's own chain so
// fine bins line up) and the pulse generator's state encoding.
package tdc_pkg;

  localparam int CHAIN_LEN = 143;

  typedef logic [1:0] state_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/tdc_pulse_generator_if.sv
// Request/config bus and pulse outputs of the self-test pulse generator.
interface tdc_pulse_generator_if #(
  parameter int COARSE_W = 32,
  parameter int FINE_W   = 8
);
  logic                go;
  logic [COARSE_W-1:0] coarse_delay;
  logic [FINE_W-1:0]   fine_delay;
  logic [7:0]          burst_count;
  logic [15:0]         gap_cycles;
  logic                start_signal;
  logic                stop_signal;
  logic                busy;
  logic                done;
  logic [7:0]          pairs_sent;

  modport master (
    output go, coarse_delay, fine_delay, burst_count, gap_cycles,
    input  start_signal, stop_signal, busy, done, pairs_sent
  );

  modport slave (
    input  go, coarse_delay, fine_delay, burst_count, gap_cycles,
    output start_signal, stop_signal, busy, done, pairs_sent
  );
endinterface

// File: rtl/tdc_pulse_generator_tap.sv
// Inverter-pair delay chain mirroring the TDC chain, with a tap mux.
// Tap 0 is the input itself; tap i sits after i inverter pairs.
module tdc_tap_delay_line #(
  parameter int CHAIN_LEN = 143,
  parameter int FINE_W    = 8
) (
  input  logic              in,
  input  logic [FINE_W-1:0] sel,
  output logic              out
);

  (* keep = "true", dont_touch = "true" *) logic [CHAIN_LEN-1:0] tap;
  (* keep = "true", dont_touch = "true" *) logic [CHAIN_LEN-1:1] mid;

  assign tap[0] = in;

  for (genvar i = 1; i < CHAIN_LEN; i++) begin : g_pair
    assign mid[i] = ~tap[i-1];
    assign tap[i] = ~mid[i];
  end

  // sel is clamped upstream and only changes while the stop path is idle
  assign out = tap[sel];

endmodule

// File: rtl/tdc_pulse_generator.sv
// Start/stop pulse-pair generator for TDC self-test: FSM, coarse counter,
// registered outputs, and a fine tap chain on the stop path.
module tdc_pulse_generator
  import tdc_pkg::*;
#(
  parameter int COARSE_W = 32,
  parameter int FINE_W   = 8,
  parameter int PULSE_W  = 4
) (
  input  logic                  sampling_clk,
  input  logic                  reset_internal_logic,
  tdc_pulse_generator_if.slave  bus
);

  localparam int TW = COARSE_W + 1;
  localparam logic [FINE_W-1:0] FINE_MAX = FINE_W'(CHAIN_LEN - 1);

  state_t              state_q, state_d;
  logic [TW-1:0]       t_q, t_d;
  logic [15:0]         gap_q, gap_d;
  logic [COARSE_W-1:0] coarse_q, coarse_d;
  logic [FINE_W-1:0]   fine_q, fine_d;
  logic [7:0]          burst_q, burst_d;
  logic [7:0]          pairs_q, pairs_d;
  logic                start_q, stop_raw_q, busy_q, done_q;

  logic [TW-1:0] stop_lo, stop_hi, last_t;
  logic          in_run, pair_end, last_pair, gap_end;

  // t is one bit wider than coarse so the end-of-pair point never wraps
  assign stop_lo   = {1'b0, coarse_q};
  assign stop_hi   = stop_lo + TW'(PULSE_W);
  assign last_t    = stop_hi - TW'(1);
  assign in_run    = (state_q == S_RUN);
  assign pair_end  = in_run && (t_q == last_t);
  assign last_pair = ({1'b0, pairs_q} + 9'd1) >= {1'b0, burst_q};
  assign gap_end   = ({1'b0, gap_q} + 17'd1) >= {1'b0, bus.gap_cycles};

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    gap_d    = gap_q;
    coarse_d = coarse_q;
    fine_d   = fine_q;
    burst_d  = burst_q;
    pairs_d  = pairs_q;
    case (state_q)
      S_IDLE: begin
        // busy_q still high means done is showing; that go is dropped
        if (bus.go && !busy_q) begin
          coarse_d = bus.coarse_delay;
          fine_d   = (bus.fine_delay > FINE_MAX) ? FINE_MAX : bus.fine_delay;
          burst_d  = (bus.burst_count == 8'd0) ? 8'd1 : bus.burst_count;
          pairs_d  = 8'd0;
          t_d      = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        t_d = t_q + TW'(1);
        if (pair_end) begin
          pairs_d = (pairs_q == 8'hFF) ? pairs_q : pairs_q + 8'd1;
          t_d     = '0;
          if (last_pair) begin
            state_d = S_DONE;
          end else if (bus.gap_cycles != 16'd0) begin
            gap_d   = 16'd0;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_end) begin
          t_d     = '0;
          state_d = S_RUN;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sampling_clk or negedge reset_internal_logic) begin
    if (!reset_internal_logic) begin
      state_q    <= S_IDLE;
      t_q        <= '0;
      gap_q      <= '0;
      coarse_q   <= '0;
      fine_q     <= '0;
      burst_q    <= 8'd1;
      pairs_q    <= '0;
      start_q    <= 1'b0;
      stop_raw_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      gap_q      <= gap_d;
      coarse_q   <= coarse_d;
      fine_q     <= fine_d;
      burst_q    <= burst_d;
      pairs_q    <= pairs_d;
      start_q    <= in_run && (t_q < TW'(PULSE_W));
      stop_raw_q <= in_run && (t_q >= stop_lo) && (t_q < stop_hi);
      busy_q     <= (state_q != S_IDLE);
      done_q     <= (state_q == S_DONE);
    end
  end

  tdc_tap_delay_line #(
    .CHAIN_LEN (CHAIN_LEN),
    .FINE_W    (FINE_W)
  ) u_line (
    .in  (stop_raw_q),
    .sel (fine_q),
    .out (bus.stop_signal)
  );

  assign bus.start_signal = start_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.pairs_sent   = pairs_q;

endmodule

// File: tb/tb_tdc_pulse_generator.sv
// Randomized + directed bench for tdc_pulse_generator against a timeline
// model derived from pair period arithmetic.
module tb_tdc_pulse_generator;

  localparam int PW = 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  tdc_pulse_generator_if #(.COARSE_W(32), .FINE_W(8)) bus ();

  tdc_pulse_generator #(
    .COARSE_W (32),
    .FINE_W   (8),
    .PULSE_W  (PW)
  ) dut (
    .sampling_clk         (clk),
    .reset_internal_logic (rst_n),
    .bus                  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Expected outputs 'rel' edges after the go edge. Pair j starts j*P
  // cycles after the first one, P = coarse + PW + gap.
  function automatic void model(input int rel, input int c, input int n, input int g,
                                output bit st, output bit sp, output bit bz,
                                output bit dn, output int pr);
    int p, done_rel, j, off;
    p        = c + PW + g;
    done_rel = (n - 1) * p + c + PW + 1;
    st = 0; sp = 0;
    if (rel >= 1 && rel < done_rel) begin
      j = (rel - 1) / p;
      if (j > n - 1) j = n - 1;
      off = rel - 1 - j * p;
      st  = (off < PW);
      sp  = (off >= c) && (off < c + PW);
    end
    bz = (rel >= 1) && (rel <= done_rel);
    dn = (rel == done_rel);
    pr = 0;
    if (rel >= c + PW) begin
      pr = (rel - c - PW) / p + 1;
      if (pr > n) pr = n;
    end
  endfunction

  task automatic check_outs(input int rel, input int c, input int n, input int g);
    bit st, sp, bz, dn;
    int pr;
    model(rel, c, n, g, st, sp, bz, dn, pr);
    chk($sformatf("start r%0d", rel), bus.start_signal, st);
    chk($sformatf("stop r%0d", rel),  bus.stop_signal, sp);
    chk($sformatf("busy r%0d", rel),  bus.busy, bz);
    chk($sformatf("done r%0d", rel),  bus.done, dn);
    chk($sformatf("pairs r%0d", rel), bus.pairs_sent, pr);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " start"}, bus.start_signal, 0);
    chk({tag, " stop"},  bus.stop_signal, 0);
    chk({tag, " busy"},  bus.busy, 0);
    chk({tag, " done"},  bus.done, 0);
    chk({tag, " pairs"}, bus.pairs_sent, 0);
  endtask

  // One request; noise pulses ignored go's with scrambled config mid-burst.
  task automatic run_req(input int c, input int f, input int b, input int g, input bit noise);
    int n, done_rel, fexp;
    n        = (b == 0) ? 1 : b;
    fexp     = (f > 142) ? 142 : f;
    done_rel = (n - 1) * (c + PW + g) + c + PW + 1;
    bus.coarse_delay = 32'(c);
    bus.fine_delay   = 8'(f);
    bus.burst_count  = 8'(b);
    bus.gap_cycles   = 16'(g);
    bus.go           = 1'b1;
    @(posedge clk); #1;
    bus.go = 1'b0;
    chk("fine_sel", dut.fine_q, fexp);
    for (int rel = 0; rel <= done_rel + 2; rel++) begin
      if (rel > 0) begin
        @(posedge clk); #1;
      end
      check_outs(rel, c, n, g);
      bus.go = 1'b0;
      if (noise && rel >= 1 && rel < done_rel && $urandom_range(3) == 0) begin
        bus.go           = 1'b1;
        bus.coarse_delay = $urandom_range(40);
        bus.fine_delay   = 8'($urandom);
        bus.burst_count  = 8'($urandom);
      end
      if (rel == done_rel) begin
        bus.go = 1'b1;
        chk("fine_frozen", dut.fine_q, fexp);
      end
    end
    bus.go = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0;
    bus.go = 1'b0; bus.coarse_delay = '0; bus.fine_delay = '0;
    bus.burst_count = '0; bus.gap_cycles = '0;
    #12;
    check_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_req(5, 0, 1, 0, 0);    // single pair
    run_req(0, 40, 1, 0, 0);   // fine only
    run_req(2, 9, 3, 2, 1);    // burst with ignored go's
    run_req(7, 200, 1, 0, 0);  // fine clamp
    run_req(4, 3, 0, 3, 0);    // burst 0 -> one pair
    run_req(1, 1, 2, 0, 0);    // back-to-back pairs

    for (int i = 0; i < 20; i++)
      run_req($urandom_range(12), $urandom_range(255), $urandom_range(5),
              $urandom_range(4), 1);

    // reset mid-RUN with a long coarse delay
    bus.coarse_delay = 32'd1000; bus.fine_delay = 8'd5;
    bus.burst_count = 8'd1; bus.gap_cycles = 16'd0; bus.go = 1'b1;
    @(posedge clk); #1;
    bus.go = 1'b0;
    for (int rel = 0; rel < 10; rel++) begin
      if (rel > 0) begin
        @(posedge clk); #1;
      end
      check_outs(rel, 1000, 1, 0);
    end
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_req(3, 7, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
